// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: round-robin traffic signal sequencer.
// Each approach in turn gets GREEN -> YELLOW -> ALLRED. Pedestrian requests
// are latched per approach and granted as a walk window at the start of that
// approach's next green.
// Optional feature: define TRAFFIC_PREEMPT_EN to add emergency preemption
// (preempt / preempt_dir ports). Without it the controller is pure round-robin.
module traffic_phase_ctrl #(
  parameter int NUM_DIR     = 4,
  parameter int GREEN_TIME  = 45,
  parameter int YELLOW_TIME = 15,
  parameter int ALLRED_TIME = 5,
  parameter int PED_TIME    = 20,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_DIR-1:0]         ped_req,
`ifdef TRAFFIC_PREEMPT_EN
  input  logic                       preempt,
  input  logic [$clog2(NUM_DIR)-1:0] preempt_dir,
`endif
  output logic [3*NUM_DIR-1:0]       lights,
  output logic [NUM_DIR-1:0]         walk,
  output logic [$clog2(NUM_DIR)-1:0] active_dir
);

  localparam int DW = $clog2(NUM_DIR);

  typedef enum logic [1:0] {
    ALLRED = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DW-1:0]        dir_q, dir_d;
  logic [NUM_DIR-1:0]   ped_pend_q, ped_pend_d;
  logic                 entry_q, entry_d;       // first cycle of a GREEN
  logic                 walk_grant_q, walk_grant_d;

  logic                 preempt_w;
  logic [DW-1:0]        preempt_dir_w;
  logic                 grant;
  logic                 walk_on;
  logic [DW-1:0]        dir_next;

`ifdef TRAFFIC_PREEMPT_EN
  assign preempt_w     = preempt;
  assign preempt_dir_w = preempt_dir;
`else
  assign preempt_w     = 1'b0;
  assign preempt_dir_w = '0;
`endif

  // Request seen for the active approach in the green entry cycle (latched or live).
  assign grant    = ped_pend_q[dir_q] | ped_req[dir_q];
  assign dir_next = (dir_q == DW'(NUM_DIR - 1)) ? '0 : dir_q + 1'b1;

  // State, counter and pedestrian-latch registers; reset drops to all-red.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ALLRED;
      cnt_q        <= CNT_WIDTH'(ALLRED_TIME - 1);
      dir_q        <= DW'(NUM_DIR - 1);
      ped_pend_q   <= '0;
      entry_q      <= 1'b0;
      walk_grant_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      ped_pend_q   <= ped_pend_d;
      entry_q      <= entry_d;
      walk_grant_q <= walk_grant_d;
    end
  end

  // Next-state: phase sequencing, countdown, approach rotation, request latching.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    dir_d        = dir_q;
    entry_d      = 1'b0;
    walk_grant_d = walk_grant_q;
    ped_pend_d   = ped_pend_q | ped_req;
    // The entry cycle consumes the active approach's request; later requests
    // in this green stay latched for its next turn.
    if (entry_q) begin
      ped_pend_d[dir_q] = 1'b0;
      walk_grant_d      = grant;
    end
    case (state_q)
      ALLRED: begin
        if (cnt_q == '0) begin
          state_d = GREEN;
          cnt_d   = CNT_WIDTH'(GREEN_TIME - 1);
          entry_d = 1'b1;
          dir_d   = preempt_w ? preempt_dir_w : dir_next;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GREEN: begin
        if (preempt_w && (preempt_dir_w != dir_q)) begin
          state_d = YELLOW;
          cnt_d   = CNT_WIDTH'(YELLOW_TIME - 1);
        end else if (preempt_w) begin
          cnt_d = cnt_q;  // preempting approach holds green until release
        end else if (cnt_q == '0) begin
          state_d = YELLOW;
          cnt_d   = CNT_WIDTH'(YELLOW_TIME - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      YELLOW: begin
        if (cnt_q == '0) begin
          state_d = ALLRED;
          cnt_d   = CNT_WIDTH'(ALLRED_TIME - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ALLRED;
        cnt_d   = CNT_WIDTH'(ALLRED_TIME - 1);
      end
    endcase
  end

  // Walk window: first PED_TIME cycles of a granted green, never under preemption.
  assign walk_on = (state_q == GREEN) && !preempt_w &&
                   (cnt_q >= CNT_WIDTH'(GREEN_TIME - PED_TIME)) &&
                   (entry_q ? grant : walk_grant_q);

  assign active_dir = dir_q;

  // Per-approach light and walk decode from registered state.
  for (genvar d = 0; d < NUM_DIR; d++) begin : g_dir
    logic sel;
    assign sel = (dir_q == DW'(d));
    assign lights[3*d+2 -: 3] = (sel && state_q == GREEN)  ? 3'b001 :
                                (sel && state_q == YELLOW) ? 3'b010 : 3'b100;
    assign walk[d] = walk_on && sel;
  end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl (NUM_DIR=4, G=5, Y=2, AR=1, PED=3).
// Covers reset release, round-robin rotation, pedestrian pulses, reset during
// walk and, when TRAFFIC_PREEMPT_EN is defined, preemption.
module tb_traffic_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ped_req;
  logic [11:0] lights;
  logic [3:0]  walk;
  logic [1:0]  active_dir;
`ifdef TRAFFIC_PREEMPT_EN
  logic        preempt;
  logic [1:0]  preempt_dir;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Expected light words: green / yellow for approach d, all others red.
  logic [11:0] green_l  [4] = '{12'h921, 12'h90C, 12'h864, 12'h324};
  logic [11:0] yellow_l [4] = '{12'h922, 12'h914, 12'h8A4, 12'h524};
  localparam logic [11:0] ALL_RED = 12'h924;

  traffic_phase_ctrl #(
    .NUM_DIR(4), .GREEN_TIME(5), .YELLOW_TIME(2),
    .ALLRED_TIME(1), .PED_TIME(3), .CNT_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ped_req    (ped_req),
`ifdef TRAFFIC_PREEMPT_EN
    .preempt    (preempt),
    .preempt_dir(preempt_dir),
`endif
    .lights     (lights),
    .walk       (walk),
    .active_dir (active_dir)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one full 8-cycle phase of approach d starting at its first green
  // cycle. w: expect walk[d] in the first 3 green cycles. A 1-cycle ped_req
  // pulse on pdir is driven on green cycle index pcyc (pcyc<0: none).
  task automatic phase(input int d, input bit w, input int pdir, input int pcyc);
    for (int i = 0; i < 8; i++) begin
      if (i < 5) begin
        chk($sformatf("green_l d%0d c%0d", d, i), lights, green_l[d]);
        chk($sformatf("walk d%0d c%0d", d, i), walk, (w && i < 3) ? (32'd1 << d) : 32'd0);
      end else if (i < 7) begin
        chk($sformatf("yellow_l d%0d c%0d", d, i), lights, yellow_l[d]);
        chk($sformatf("walk_y d%0d c%0d", d, i), walk, 0);
      end else begin
        chk($sformatf("allred_l d%0d", d), lights, ALL_RED);
      end
      chk($sformatf("dir d%0d c%0d", d, i), active_dir, d);
      if (i == pcyc) ped_req = 4'b1 << pdir;
      step();
      ped_req = '0;
    end
  endtask

  initial begin
    rst     = 1'b1;
    ped_req = '0;
`ifdef TRAFFIC_PREEMPT_EN
    preempt     = 1'b0;
    preempt_dir = '0;
`endif
    step();
    step();
    chk("rst_lights", lights, ALL_RED);
    chk("rst_walk", walk, 0);
    chk("rst_dir", active_dir, 3);

    // Release; approach 0 green one cycle later.
    rst = 1'b0;
    step();
    phase(0, 1'b0, 2, 1);   // pulse ped_req[2] in approach 0 green
    phase(1, 1'b0, 1, 2);   // ped_req[1] on 3rd cycle of own green: deferred
    phase(2, 1'b1, 0, -1);  // walk from the earlier pulse
    phase(3, 1'b0, 0, -1);
    phase(0, 1'b0, 0, -1);  // wrap back to approach 0
    phase(1, 1'b1, 2, 0);   // deferred walk now; queue one for approach 2

    // Approach 2 green with walk; reset on the 2nd walk cycle.
    chk("w2_c0_l", lights, green_l[2]);
    chk("w2_c0_w", walk, 4'b0100);
    step();
    chk("w2_c1_w", walk, 4'b0100);
    rst = 1'b1;
    #1;
    chk("midrst_lights", lights, ALL_RED);
    chk("midrst_walk", walk, 0);
    chk("midrst_dir", active_dir, 3);
    step();
    step();
    rst = 1'b0;
    step();
    phase(0, 1'b0, 0, -1);  // pending request was discarded

`ifdef TRAFFIC_PREEMPT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("pre_g0_c0", lights, green_l[0]);
    step();
    chk("pre_g0_c1", lights, green_l[0]);
    preempt     = 1'b1;
    preempt_dir = 2'd3;
    step();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("pre_y%0d", i), lights, yellow_l[0]);
      step();
    end
    chk("pre_ar", lights, ALL_RED);
    step();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("pre_hold%0d", i), lights, green_l[3]);
      chk($sformatf("pre_hold_dir%0d", i), active_dir, 3);
      chk($sformatf("pre_hold_walk%0d", i), walk, 0);
      step();
    end
    preempt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("pre_rel%0d", i), lights, green_l[3]);
      step();
    end
    chk("pre_rel_y", lights, yellow_l[3]);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
